// File: rtl/conv2_k_reg_loader.sv
// conv2 kernel register loader: gathers paired weight words from the two ROM read
// ports into 25-tap shadow banks and promotes each complete pair to the MAC-facing banks.
module conv2_k_reg_loader #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 25,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [DATA_W-1:0]      q0,
    input  logic [DATA_W-1:0]      q1,
    output logic                   load_stall,
    output logic [TAPS*DATA_W-1:0] w0_flat,
    output logic [TAPS*DATA_W-1:0] w1_flat,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [7:0]             set_count,
    output logic                   err_overrun
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PEND_W = $clog2(RD_LAT + 1);
    localparam int SUM_W  = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

    logic [RD_LAT-1:0]      rd_vld_p;
    logic                   cap;
    logic [PEND_W-1:0]      pend;
    logic [SUM_W-1:0]       fill;
    logic [IDX_W-1:0]       idx;
    logic                   shadow_full;
    logic [TAPS*DATA_W-1:0] shadow0;
    logic [TAPS*DATA_W-1:0] shadow1;
    logic                   promote;

    assign cap = rd_vld_p[RD_LAT-1];

    always_comb begin
        pend = '0;
        for (int i = 0; i < RD_LAT; i++) pend = pend + PEND_W'(rd_vld_p[i]);
    end

    // Reads still in flight already own a shadow slot, so they count toward the fill level.
    assign fill       = SUM_W'(idx) + SUM_W'(pend);
    assign load_stall = shadow_full | (fill >= SUM_W'(TAPS));
    assign promote    = shadow_full & (~w_valid | w_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_p    <= '0;
            idx         <= '0;
            shadow_full <= 1'b0;
            shadow0     <= '0;
            shadow1     <= '0;
            w0_flat     <= '0;
            w1_flat     <= '0;
            w_valid     <= 1'b0;
            set_count   <= '0;
            err_overrun <= 1'b0;
        end else begin
            // Read-latency pipe: rd_en reappears as cap once the ROM data is on q0/q1.
            rd_vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];

            if (cap) begin
                if (!shadow_full) begin
                    shadow0[int'(idx)*DATA_W +: DATA_W] <= q0;
                    shadow1[int'(idx)*DATA_W +: DATA_W] <= q1;
                    if (idx == LAST_TAP) begin
                        idx         <= '0;
                        shadow_full <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end else begin
                    err_overrun <= 1'b1;
                end
            end

            // Shadow-to-active boundary; a consumed pair is replaced without a bubble.
            if (promote) begin
                w0_flat     <= shadow0;
                w1_flat     <= shadow1;
                w_valid     <= 1'b1;
                shadow_full <= 1'b0;
                set_count   <= set_count + 8'd1;
            end else if (w_valid && w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv2_k_reg_loader.sv
// Scoreboard bench for conv2_k_reg_loader: a kernel-level reference model predicts
// per-cycle status and every promoted weight pair; a monitor pops and compares.
module tb_conv2_k_reg_loader;
    localparam int DATA_W = 8;
    localparam int TAPS   = 25;
    localparam int RD_LAT = 3;
    localparam int FW     = TAPS * DATA_W;

    logic              clk, reset, rd_en, w_ready;
    logic [DATA_W-1:0] q0, q1;
    logic              load_stall, w_valid, err_overrun;
    logic [FW-1:0]     w0_flat, w1_flat;
    logic [7:0]        set_count;

    conv2_k_reg_loader #(.DATA_W(DATA_W), .TAPS(TAPS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .q0(q0), .q1(q1),
        .load_stall(load_stall), .w0_flat(w0_flat), .w1_flat(w1_flat),
        .w_valid(w_valid), .w_ready(w_ready), .set_count(set_count),
        .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit en; logic [DATA_W-1:0] d0; logic [DATA_W-1:0] d1; } iss_t;
    typedef struct { logic stall; logic valid; logic err; logic [7:0] cnt; } st_t;
    typedef struct { logic [FW-1:0] w0; logic [FW-1:0] w1; } pair_t;

    iss_t              hist[$];   // words requested but not yet returned by the ROM
    st_t               st_q[$];
    pair_t             pair_q[$];
    logic [DATA_W-1:0] sh0[$], sh1[$];
    bit                m_valid, m_err;
    logic [7:0]        m_cnt;
    int                checks = 0;
    int                errors = 0;
    int                issued, cycles;
    bit                en;
    logic [DATA_W-1:0] first_q0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic st_t zero_st();
        st_t s;
        s.stall = 1'b0; s.valid = 1'b0; s.err = 1'b0; s.cnt = 8'd0;
        return s;
    endfunction

    // One clock of stimulus, entered and left 1 time unit after a rising edge.
    task automatic cyc(input bit e, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input bit rdy);
        iss_t  ret, nw;
        st_t   s;
        pair_t p;
        int    pend;
        bit    full;
        pend = 0;
        foreach (hist[i]) pend += int'(hist[i].en);
        ret = hist.pop_front();
        nw.en = e; nw.d0 = a; nw.d1 = b;
        hist.push_back(nw);
        rd_en   = e;
        w_ready = rdy;
        q0 = ret.en ? ret.d0 : DATA_W'($urandom);
        q1 = ret.en ? ret.d1 : DATA_W'($urandom);
        full = (sh0.size() == TAPS);
        s.stall = full || (sh0.size() + pend >= TAPS);
        s.valid = m_valid; s.err = m_err; s.cnt = m_cnt;
        st_q.push_back(s);
        if (ret.en) begin
            if (!full) begin
                sh0.push_back(ret.d0);
                sh1.push_back(ret.d1);
            end else begin
                m_err = 1'b1;
            end
        end
        if (full && (!m_valid || rdy)) begin
            for (int k = 0; k < TAPS; k++) begin
                p.w0[k*DATA_W +: DATA_W] = sh0[k];
                p.w1[k*DATA_W +: DATA_W] = sh1[k];
            end
            pair_q.push_back(p);
            sh0.delete(); sh1.delete();
            m_valid = 1'b1;
            m_cnt   = m_cnt + 8'd1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        iss_t z;
        reset = 1'b1; rd_en = 1'b0; w_ready = 1'b0;
        q0 = DATA_W'($urandom); q1 = DATA_W'($urandom);
        hist.delete(); pair_q.delete(); sh0.delete(); sh1.delete();
        z.en = 1'b0; z.d0 = '0; z.d1 = '0;
        for (int i = 0; i < RD_LAT; i++) hist.push_back(z);
        m_valid = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
        st_q.push_back(zero_st());
        #1;
        checkw("rst_w0", w0_flat, '0);
        checkw("rst_w1", w1_flat, '0);
        check8("rst_cnt", set_count, 8'd0);
        @(posedge clk); #1;
        st_q.push_back(zero_st());
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        st_t   s;
        pair_t p;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            check8("load_stall", 8'(load_stall), 8'(s.stall));
            check8("w_valid", 8'(w_valid), 8'(s.valid));
            check8("err_overrun", 8'(err_overrun), 8'(s.err));
            check8("set_count", set_count, s.cnt);
        end
        if (w_valid && w_ready && !reset) begin
            if (pair_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pair_unexpected got w_valid 1 want no pending pair at %0t", $time);
            end else begin
                p = pair_q.pop_front();
                checkw("pair_w0", w0_flat, p.w0);
                checkw("pair_w1", w1_flat, p.w1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got no finish want finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rd_en = 1'b0; w_ready = 1'b0; q0 = '0; q1 = '0;
        @(posedge clk); #1;
        do_reset();

        // Single load with ramp data.
        for (int k = 0; k < TAPS; k++) cyc(1'b1, DATA_W'(k), DATA_W'(100 + k), 1'b0);
        idle(RD_LAT + 3);
        check8("p1_valid", 8'(w_valid), 8'd1);
        check8("p1_w0_t0", w0_flat[0 +: DATA_W], 8'd0);
        check8("p1_w0_t24", w0_flat[24*DATA_W +: DATA_W], 8'd24);
        check8("p1_w1_t24", w1_flat[24*DATA_W +: DATA_W], 8'd124);
        check8("p1_cnt", set_count, 8'd1);
        check8("p1_stall", 8'(load_stall), 8'd0);

        // Back-pressure: second set fills while the first is held.
        issued = 0;
        for (int c = 0; c < 200 && issued < TAPS; c++) begin
            en = !load_stall;
            if (en) issued++;
            cyc(en, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        end
        check8("p2_issued", 8'(issued), 8'(TAPS));
        idle(RD_LAT + 2);
        check8("p2_stall", 8'(load_stall), 8'd1);
        check8("p2_hold_t0", w0_flat[0 +: DATA_W], 8'd0);
        cyc(1'b0, '0, '0, 1'b1);
        check8("p2_cnt", set_count, 8'd2);
        check8("p2_valid", 8'(w_valid), 8'd1);
        check8("p2_stall_drop", 8'(load_stall), 8'd0);

        // Lookahead stall: a compliant upstream gets exactly one set in.
        issued = 0;
        for (int c = 0; c < 60; c++) begin
            en = !load_stall;
            if (en) issued++;
            cyc(en, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        end
        check8("p3_issued", 8'(issued), 8'(TAPS));
        check8("p3_no_overrun", 8'(err_overrun), 8'd0);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);

        // Overrun: 26 requests ignoring load_stall.
        for (int c = 0; c < TAPS + 1; c++) cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        idle(RD_LAT + 2);
        check8("p4_overrun", 8'(err_overrun), 8'd1);
        cyc(1'b0, '0, '0, 1'b1);
        idle(1);
        cyc(1'b0, '0, '0, 1'b1);
        idle(2);
        check8("p4_sticky", 8'(err_overrun), 8'd1);

        // Reset in the middle of a load.
        for (int c = 0; c < 10; c++) cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        idle(RD_LAT);
        do_reset();
        first_q0 = DATA_W'($urandom);
        cyc(1'b1, first_q0, DATA_W'($urandom), 1'b0);
        for (int c = 1; c < TAPS; c++) cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
        idle(RD_LAT + 3);
        check8("p5_valid", 8'(w_valid), 8'd1);
        check8("p5_tap0", w0_flat[0 +: DATA_W], first_q0);
        cyc(1'b0, '0, '0, 1'b1);

        // Random traffic until set_count wraps back to zero.
        cycles = 0;
        while (m_cnt != 8'd0 && cycles < 40000) begin
            en = !load_stall && ($urandom_range(3) != 0);
            cyc(en, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(1)));
            cycles++;
        end
        checks++;
        if (cycles >= 40000) begin
            errors++;
            $display("FAIL wrap_budget got %0d cycles want fewer than 40000", cycles);
        end
        check8("wrap_cnt", set_count, 8'd0);
        for (int c = 0; c < RD_LAT + 6; c++) cyc(1'b0, '0, '0, 1'b1);
        check8("drain_pairs", 8'(pair_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
